// File: rtl/prio_arbiter8.sv
// ----------------------------------------------------------------------------
// prio_arbiter8 : 8-requester arbiter with hold limit and registered grant outputs.
// Highest set Req bit wins unless PRIO_ARBITER8_RR_EN selects rotating priority.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module prio_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] Req,
   input  logic       Done,
   output logic [7:0] Gnt,
   output logic [2:0] GntIdx,
   output logic       GntValid,
   output logic       Timeout
);

   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       gnt_q, gnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       win;
`ifdef PRIO_ARBITER8_RR_EN
   logic [2:0]       last_q, last_d;
   logic [2:0]       cand;
`endif

   // Winner search: the last assignment in loop order has the highest priority.
   always_comb begin
      win = 3'd0;
`ifdef PRIO_ARBITER8_RR_EN
      cand = 3'd0;
      for (int p = 8; p >= 1; p--) begin
         cand = last_q - 3'(p);
         if (Req[cand]) win = cand;
      end
`else
      for (int i = 0; i < 8; i++) begin
         if (Req[i]) win = 3'(i);
      end
`endif
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
`ifdef PRIO_ARBITER8_RR_EN
      last_d    = last_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (|Req) begin
               state_d = BUSY;
               gnt_d   = 8'b1 << win;
               idx_d   = win;
               valid_d = 1'b1;
`ifdef PRIO_ARBITER8_RR_EN
               last_d  = win;
`endif
            end
         end
         BUSY: begin
            if (Done || !Req[idx_q] || (cnt_q == CNT_LAST)) begin
               state_d   = GAP;
               gnt_d     = 8'd0;
               idx_d     = 3'd0;
               valid_d   = 1'b0;
               cnt_d     = '0;
               // Flag only a release forced purely by the hold limit.
               timeout_d = !Done && Req[idx_q];
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 8'd0;
            idx_d   = 3'd0;
            valid_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= 8'd0;
         idx_q     <= 3'd0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
`ifdef PRIO_ARBITER8_RR_EN
         last_q    <= 3'd0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
`ifdef PRIO_ARBITER8_RR_EN
         last_q    <= last_d;
`endif
      end
   end

   assign Gnt      = gnt_q;
   assign GntIdx   = idx_q;
   assign GntValid = valid_q;
   assign Timeout  = timeout_q;

endmodule

`default_nettype wire
